// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 bus bundle for ei_axi4_slave_mem: AW/W/B write channels and AR/R read channels.
interface ei_axi4_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed memory. Independent write (AW/W/B) and read (AR/R)
// FSMs, one burst at a time each; FIXED/INCR/WRAP bursts, byte strobes, ID echo.
// Optional macro EI_AXI4_SLV_ERR_EN: out-of-range word indices return SLVERR instead of
// wrapping modulo MEM_DEPTH.
module ei_axi4_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic                aclk,
  input logic                aresetn,
  ei_axi4_slave_mem_if.slave slv
);
  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
  localparam int unsigned MemAw   = $clog2(MEM_DEPTH);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

`ifdef EI_AXI4_SLV_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef logic [IdxW-1:0] idx_t;

  // Next beat index. The index keeps its full width so an out-of-range check sees the value
  // before the modulo; memory accesses use only the low MemAw bits.
  function automatic idx_t next_idx(idx_t idx, logic [7:0] len, logic [1:0] burst);
    idx_t mask;
    idx_t inc;
    idx_t res;
    logic wrap_ok;
    mask    = idx_t'(len);
    inc     = idx + idx_t'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == BurstFixed) begin
      res = idx;
    end else if (burst == BurstWrap && wrap_ok) begin
      res = (idx & ~mask) | (inc & mask);
    end else begin
      res = inc;
    end
    return res;
  endfunction

  function automatic logic idx_oob(idx_t idx);
    return ErrEn && (idx >= idx_t'(MEM_DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // wlast is deliberately ignored: the beat counter ends the burst.
  logic unused_wlast;
  assign unused_wlast = slv.wlast;

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  idx_t                  w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  mem_we;
  logic                  w_oob;

  assign w_oob = idx_oob(w_idx_q);

  // Write FSM next state, beat bookkeeping and memory write enable
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (slv.awvalid && awready_q) begin
          bid_d     = slv.awid;
          w_idx_d   = idx_t'(slv.awaddr >> AddrLsb);
          w_len_d   = slv.awlen;
          w_burst_d = slv.awburst;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (slv.wvalid) begin
          mem_we  = !w_oob;
          w_err_d = w_err_q | w_oob;
          w_idx_d = next_idx(w_idx_q, w_len_q, w_burst_q);
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            bresp_d   = (w_err_q | w_oob) ? RespSlvErr : RespOkay;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (slv.bready) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle);
  end

  // Write FSM state and captured burst attributes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
    end
  end

  // Byte-strobed memory write; storage is intentionally not reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (slv.wstrb[b]) begin
          mem_q[w_idx_q[MemAw-1:0]][b*8 +: 8] <= slv.wdata[b*8 +: 8];
        end
      end
    end
  end

  assign slv.awready = awready_q;
  assign slv.wready  = (w_state_q == WData);
  assign slv.bvalid  = (w_state_q == WResp);
  assign slv.bid     = bid_q;
  assign slv.bresp   = bresp_q;

  // ---------------------------------------------------------------- read path
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  idx_t                  r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            r_burst_q, r_burst_d;
  idx_t                  r_ld_idx;
  logic [DATA_WIDTH-1:0] r_ld_word;
  logic                  r_ld_oob;

  // Index of the beat to be loaded into the output register next. Beats are registered at
  // load time, so a same-cycle write to that word is not seen and a stalled beat never changes.
  assign r_ld_idx  = (r_state_q == RIdle) ? idx_t'(slv.araddr >> AddrLsb)
                                          : next_idx(r_idx_q, r_len_q, r_burst_q);
  assign r_ld_word = mem_q[r_ld_idx[MemAw-1:0]];
  assign r_ld_oob  = idx_oob(r_ld_idx);

  // Read FSM next state and next beat load
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    unique case (r_state_q)
      RIdle: begin
        if (slv.arvalid && arready_q) begin
          rid_d     = slv.arid;
          r_idx_d   = r_ld_idx;
          r_len_d   = slv.arlen;
          r_burst_d = slv.arburst;
          r_cnt_d   = 8'd0;
          rlast_d   = (slv.arlen == 8'd0);
          rdata_d   = r_ld_oob ? '0 : r_ld_word;
          rresp_d   = r_ld_oob ? RespSlvErr : RespOkay;
          r_state_d = RData;
        end
      end
      RData: begin
        if (slv.rready) begin
          if (r_cnt_q == r_len_q) begin
            rlast_d   = 1'b0;
            r_state_d = RIdle;
          end else begin
            r_idx_d = r_ld_idx;
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
            rdata_d = r_ld_oob ? '0 : r_ld_word;
            rresp_d = r_ld_oob ? RespSlvErr : RespOkay;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle);
  end

  // Read FSM state and registered R channel outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
    end
  end

  assign slv.arready = arready_q;
  assign slv.rvalid  = (r_state_q == RData);
  assign slv.rid     = rid_q;
  assign slv.rdata   = rdata_q;
  assign slv.rresp   = rresp_q;
  assign slv.rlast   = rlast_q;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Self-checking bench for ei_axi4_slave_mem: directed scenarios plus randomized bursts checked
// against an array-based memory model with arithmetic burst address rules.
module tb_ei_axi4_slave_mem;
  localparam int unsigned Depth = 1024;
`ifdef EI_AXI4_SLV_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  logic [31:0] m_mem [Depth];
  logic [31:0] wd_a  [256];
  logic [3:0]  ws_a  [256];
  logic [31:0] er_d  [256];
  logic [1:0]  er_r  [256];

  ei_axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) ax ();

  ei_axi4_slave_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH  (4),
    .MEM_DEPTH (Depth)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .slv    (ax)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next word index from the burst rules: WRAP stays inside its aligned (len+1)-word block.
  function automatic int unsigned m_next(int unsigned idx, int unsigned len, int unsigned burst);
    int unsigned sz;
    sz = len + 1;
    if (burst == 0) return idx;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15))
      return (idx / sz) * sz + ((idx % sz) + 1) % sz;
    return ErrEn ? idx + 1 : (idx + 1) % Depth;
  endfunction

  function automatic logic [1:0] m_write(int unsigned addr, int unsigned len, int unsigned burst);
    int unsigned idx;
    bit          err;
    idx = addr / 4;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (ErrEn && idx >= Depth) begin
        err = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (ws_a[i][b]) m_mem[idx % Depth][8*b +: 8] = wd_a[i][8*b +: 8];
      end
      idx = m_next(idx, len, burst);
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic void m_read(int unsigned addr, int unsigned len, int unsigned burst);
    int unsigned idx;
    idx = addr / 4;
    for (int i = 0; i <= int'(len); i++) begin
      if (ErrEn && idx >= Depth) begin
        er_d[i] = 32'h0;
        er_r[i] = 2'b10;
      end else begin
        er_d[i] = m_mem[idx % Depth];
        er_r[i] = 2'b00;
      end
      idx = m_next(idx, len, burst);
    end
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                         input logic [1:0] burst);
    int g;
    @(negedge aclk);
    ax.awid = id; ax.awaddr = addr; ax.awlen = len[7:0]; ax.awburst = burst; ax.awvalid = 1'b1;
    g = 0;
    while (!ax.awready && g < 50) begin @(negedge aclk); g++; end
    chk("aw_accept", 64'(ax.awready), 64'd1);
    @(negedge aclk);
    ax.awvalid = 1'b0;
    chk("aw_drop", 64'(ax.awready), 64'd0);
    chk("w_rise", 64'(ax.wready), 64'd1);
  endtask

  task automatic w_beat(input int i, input bit last, input bit bp);
    int g;
    if (bp) begin
      ax.wvalid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge aclk);
    end
    ax.wdata = wd_a[i]; ax.wstrb = ws_a[i]; ax.wlast = last; ax.wvalid = 1'b1;
    g = 0;
    while (!ax.wready && g < 50) begin @(negedge aclk); g++; end
    chk("w_accept", 64'(ax.wready), 64'd1);
    @(negedge aclk);
    ax.wvalid = 1'b0;
    ax.wlast  = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                           input logic [1:0] burst, input bit bp, input logic [1:0] exp_resp);
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) w_beat(i, i == int'(len), bp);
    chk("b_rise", 64'(ax.bvalid), 64'd1);
    chk("bid", 64'(ax.bid), 64'(id));
    chk("bresp", 64'(ax.bresp), 64'(exp_resp));
    if (bp) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge aclk);
        chk("b_hold", 64'({ax.bvalid, ax.bid, ax.bresp}), 64'({1'b1, id, exp_resp}));
      end
    end
    ax.bready = 1'b1;
    @(negedge aclk);
    ax.bready = 1'b0;
    chk("b_fall", 64'(ax.bvalid), 64'd0);
    chk("aw_return", 64'(ax.awready), 64'd1);
  endtask

  // mode 0: rready held high, 1: toggling starting low, 2: random
  task automatic axi_read(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                          input logic [1:0] burst, input int mode);
    int          g;
    int          beat;
    bit          stalled;
    bit          tog;
    logic [63:0] snap;
    m_read(addr, len, burst);
    @(negedge aclk);
    ax.arid = id; ax.araddr = addr; ax.arlen = len[7:0]; ax.arburst = burst; ax.arvalid = 1'b1;
    g = 0;
    while (!ax.arready && g < 50) begin @(negedge aclk); g++; end
    chk("ar_accept", 64'(ax.arready), 64'd1);
    @(negedge aclk);
    ax.arvalid = 1'b0;
    chk("ar_drop", 64'(ax.arready), 64'd0);
    chk("r_rise", 64'(ax.rvalid), 64'd1);
    beat = 0; g = 0; stalled = 1'b0; tog = 1'b0; snap = '0;
    while (beat <= int'(len) && g < 2000) begin
      ax.rready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      if (stalled)
        chk("r_stable", 64'({ax.rvalid, ax.rdata, ax.rlast, ax.rid, ax.rresp}), snap);
      if (ax.rvalid && ax.rready) begin
        chk("rdata", 64'(ax.rdata), 64'(er_d[beat]));
        chk("rresp", 64'(ax.rresp), 64'(er_r[beat]));
        chk("rlast", 64'(ax.rlast), 64'(beat == int'(len)));
        chk("rid", 64'(ax.rid), 64'(id));
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = ax.rvalid;
        snap = 64'({ax.rvalid, ax.rdata, ax.rlast, ax.rid, ax.rresp});
      end
      @(negedge aclk);
      g++;
    end
    ax.rready = 1'b0;
    chk("r_beats", 64'(beat), 64'(len + 1));
    chk("r_fall", 64'(ax.rvalid), 64'd0);
    chk("ar_return", 64'(ax.arready), 64'd1);
  endtask

  initial begin
    logic [1:0]  exp_resp;
    int unsigned b;
    int unsigned l;
    int unsigned a;
    checks = 0;
    errors = 0;
    aresetn = 1'b0;
    ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awburst = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arburst = '0; ax.arvalid = 1'b0;
    ax.rready = 1'b0;

    // Reset state
    #23;
    chk("rst_awready", 64'(ax.awready), 64'd0);
    chk("rst_arready", 64'(ax.arready), 64'd0);
    chk("rst_outs", 64'({ax.wready, ax.bvalid, ax.bid, ax.bresp, ax.rvalid, ax.rlast,
                         ax.rid, ax.rresp}), 64'd0);
    chk("rst_rdata", 64'(ax.rdata), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_awready", 64'(ax.awready), 64'd1);
    chk("post_rst_arready", 64'(ax.arready), 64'd1);

    // Fill words 0..63 so every later read hits known data
    for (int i = 0; i < 64; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
    exp_resp = m_write(0, 63, 1);
    axi_write(4'd1, 0, 63, 2'b01, 1'b0, exp_resp);

    // Single write/read
    wd_a[0] = 32'hDEADBEEF; ws_a[0] = 4'hF;
    exp_resp = m_write(32'h10, 0, 1);
    axi_write(4'd3, 32'h10, 0, 2'b01, 1'b0, 2'b00);
    axi_read(4'd5, 32'h10, 0, 2'b01, 0);

    // INCR burst, read back with rready toggling
    for (int i = 0; i < 4; i++) begin wd_a[i] = 32'(i + 1); ws_a[i] = 4'hF; end
    exp_resp = m_write(0, 3, 1);
    axi_write(4'd2, 0, 3, 2'b01, 1'b0, exp_resp);
    axi_read(4'd6, 0, 3, 2'b01, 1);

    // WRAP burst at 0x08, then linear read from 0x0
    wd_a[0] = 32'hA; wd_a[1] = 32'hB; wd_a[2] = 32'hC; wd_a[3] = 32'hD;
    exp_resp = m_write(32'h08, 3, 2);
    axi_write(4'd7, 32'h08, 3, 2'b10, 1'b0, exp_resp);
    axi_read(4'd8, 0, 3, 2'b01, 0);

    // Byte strobes
    wd_a[0] = 32'h12345678; ws_a[0] = 4'hF;
    exp_resp = m_write(32'h40, 0, 1);
    axi_write(4'd9, 32'h40, 0, 2'b01, 1'b0, exp_resp);
    wd_a[0] = 32'hAAAAAAAA; ws_a[0] = 4'h3;
    exp_resp = m_write(32'h40, 0, 1);
    axi_write(4'd9, 32'h40, 0, 2'b01, 1'b0, exp_resp);
    axi_read(4'd10, 32'h40, 0, 2'b01, 0);

    // Out-of-range write one past the memory end
    wd_a[0] = 32'hCAFEF00D; ws_a[0] = 4'hF;
    exp_resp = m_write(Depth * 4, 0, 1);
    axi_write(4'd11, Depth * 4, 0, 2'b01, 1'b0, exp_resp);
    axi_read(4'd12, 0, 0, 2'b01, 0);

    // Reset after 2 of 4 write beats
    for (int i = 0; i < 4; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
    exp_resp = m_write(0, 1, 1);
    aw_send(4'd4, 0, 3, 2'b01);
    w_beat(0, 1'b0, 1'b0);
    w_beat(1, 1'b0, 1'b0);
    aresetn = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      chk("midrst_outs", 64'({ax.awready, ax.wready, ax.bvalid}), 64'd0);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_awready", 64'(ax.awready), 64'd1);
    repeat (4) begin
      chk("midrst_no_b", 64'(ax.bvalid), 64'd0);
      @(negedge aclk);
    end
    axi_read(4'd13, 0, 3, 2'b01, 2);

    // Randomized bursts with backpressure on every channel
    for (int it = 0; it < 16; it++) begin
      b = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: l = 0;
        1: l = 1;
        2: l = 3;
        3: l = 7;
        4: l = 15;
        default: l = $urandom_range(0, 15);
      endcase
      a = $urandom_range(0, 47) * 4 + $urandom_range(0, 3);
      for (int i = 0; i <= int'(l); i++) begin wd_a[i] = $urandom; ws_a[i] = 4'($urandom); end
      exp_resp = m_write(a, l, b);
      axi_write(4'($urandom), a, l, b[1:0], 1'b1, exp_resp);
      b = $urandom_range(0, 3);
      l = $urandom_range(0, 15);
      a = $urandom_range(0, 47) * 4 + $urandom_range(0, 3);
      axi_read(4'($urandom), a, l, b[1:0], 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

Synthesizable AXI4 slave (responder) backed by an internal word-addressed memory. It is the target-side counterpart to the VIP master agent and interconnect, and serves as a reference DUT on the slave port of the verification environment. Write (AW/W/B) and read (AR/R) paths are independent state machines, each handling one burst at a time. FIXED, INCR and WRAP bursts are supported, with byte strobes and ID echo.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; power of two, ≥ 8
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, memory size in DATA_WIDTH words; power of two
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  asynchronous, active-low reset
- awid  in  ID_WIDTH  write ID
- awaddr  in  ADDR_WIDTH  write start byte address
- awlen  in  8  beats minus 1
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wlast  in  1  last beat flag (not used to terminate the burst)
- wvalid / wready  in / out  1  W handshake
- bid  out  ID_WIDTH  echoed awid
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid / bready  out / in  1  B handshake
- arid  in  ID_WIDTH  read ID
- araddr  in  ADDR_WIDTH  read start byte address
- arlen  in  8  beats minus 1
- arburst  in  2  burst type, same encoding as awburst
- arvalid / arready  in / out  1  AR handshake
- rid  out  ID_WIDTH  echoed arid
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rlast  out  1  asserted on the final beat
- rvalid / rready  out / in  1  R handshake

## Operation
- **Transfer size:** only full-width transfers are supported. Word index = addr >> log2(DATA_WIDTH/8); low address bits are ignored.
- **Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:**
  - W_IDLE: awready=1. On the AW handshake, capture id, index, len and burst, clear the beat counter, and move to W_DATA.
  - W_DATA: wready=1. On each W handshake, write the strobed bytes to mem[index], advance the index, and increment the counter. The handshake with counter==len moves to W_RESP; wlast is ignored.
  - W_RESP: bvalid=1 with bid and bresp held stable until bready, then return to W_IDLE.
- **Read FSM, R_IDLE → R_DATA → R_IDLE:**
  - R_IDLE: arready=1. On the AR handshake, capture id, index, len and burst.
  - R_DATA: rvalid=1 and rdata=mem[index]. rlast=1 when counter==len. Advance on rvalid&&rready; the last handshake returns to R_IDLE.
- **Address update:**
  - FIXED: index unchanged.
  - INCR: index+1, modulo MEM_DEPTH.
  - WRAP: index = (index & ~len) | ((index+1) & len). Valid only for len ∈ {1,3,7,15}; any other len is treated as INCR.
  - Burst 11 (reserved) is treated as INCR.
- **Read/write same word in the same cycle:** the read returns the pre-write data.
- **Reset:**
  - aresetn low forces both FSMs to IDLE and all outputs to 0.
  - Memory is not reset.
  - Reset mid-burst abandons the burst: no B or R beat is issued, and beats already written stay written.

## Timing
- awready and arready are registered. Both are 0 during reset and become 1 at the first rising edge with aresetn high.
- awready drops the cycle after the AW handshake; wready rises in that same cycle.
- bvalid rises the cycle after the final W handshake. awready returns the cycle after the B handshake.
- An N-beat write takes at least N+2 cycles from AW handshake to B handshake.
- rvalid rises the cycle after the AR handshake. With rready held high, beats stream one per cycle.
- arready returns the cycle after the rlast handshake.
- Outputs never change while valid is high and ready is low.

## Configuration
- **EI_AXI4_SLV_ERR_EN defined:** index ≥ MEM_DEPTH (before modulo) is out of range.
  - Out-of-range write beats are dropped, and bresp=SLVERR if any beat of the burst was out of range.
  - Out-of-range read beats return rdata=0 with rresp=SLVERR.
- **EI_AXI4_SLV_ERR_EN undefined:** the index wraps modulo MEM_DEPTH, and bresp and rresp are always OKAY.

## Test plan
1. **Single write/read:** write awid=3, awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=0xF; then read arid=5 at 0x10 → bid=3, bresp=00; rid=5, rdata=0xDEADBEEF, rlast=1, rresp=00.
2. **INCR burst with backpressure:** INCR awlen=3 at 0x0, data 1,2,3,4; read back with rready toggling every cycle → data 1,2,3,4, rlast only on beat 4, rdata stable while stalled.
3. **WRAP burst:** WRAP awlen=3 at 0x08, data A,B,C,D → words 2,3,0,1 hold A,B,C,D; an INCR read of 4 beats from 0x0 returns C,D,A,B.
4. **Byte strobes:** write 0x12345678, then wdata=0xAAAAAAAA with wstrb=0x3 to the same word → read returns 0x1234AAAA.
5. **Out-of-range write:** awaddr=MEM_DEPTH*4, awlen=0. With EI_AXI4_SLV_ERR_EN → bresp=10 and word 0 unchanged. Without it → word 0 is overwritten and bresp=00.
6. **Reset mid-burst:** assert aresetn=0 after 2 of 4 W beats → bvalid is never asserted, awready=1 after release, words 0–1 updated, words 2–3 unchanged.
